tea_decrypt_core: RTL and testbench

Iterative TEA (Tiny Encryption Algorithm) block decryptor: accepts one 64-bit ciphertext block (v0, v1) plus a 128-bit key over a valid/ready handshake, runs the standard TEA decryption schedule one half-round per clock, and returns the 64-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the switch-driven TEA encrypt machine. It operates on full 32-bit words, with no 10-bit switch truncation, so it can sit between a ciphertext source (UART/FIFO) and the display/datapath logic.

---
 rtl/tea_pkg.sv | 27 ++
 rtl/tea_f.sv | 21 ++
 rtl/tea_decrypt_core.sv | 151 +++++++++++++++
 tb/tb_tea_decrypt_core.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constant, FSM encoding and key word layout.
// Used by the iterative decryptor and intended for reuse by the pipelined encryptor.
package tea_pkg;

   localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

   // FSM encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_V1_STEP = 2'd1;
   localparam logic [1:0] ST_V0_STEP = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // 32-bit word index of each key word inside the 128-bit key bus
   localparam int unsigned KEY_K0 = 0;
   localparam int unsigned KEY_K1 = 1;
   localparam int unsigned KEY_K2 = 2;
   localparam int unsigned KEY_K3 = 3;

   // Final schedule sum of an encryption, i.e. the starting sum for decryption.
   function automatic logic [31:0] tea_sum_init(input int unsigned rounds,
                                                input logic [31:0] delta = TEA_DELTA);
      logic [63:0] prod;
      prod = 64'(rounds) * 64'(delta);
      return prod[31:0];
   endfunction

endpackage

// File: rtl/tea_f.sv
// TEA round function F(x, ka, kb, s) = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb), mod 2^32.
module tea_f (
   input  logic [31:0] x,
   input  logic [31:0] ka,
   input  logic [31:0] kb,
   input  logic [31:0] s,
   output logic [31:0] f
);

   logic [31:0] t_hi;
   logic [31:0] t_mid;
   logic [31:0] t_lo;

   always_comb begin
      t_hi  = (x << 4) + ka;
      t_mid = x + s;
      t_lo  = (x >> 5) + kb;
      f     = t_hi ^ t_mid ^ t_lo;
   end

endmodule

// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryptor: one half-round per clock, valid/ready on both sides.
// A single shared tea_f evaluates whichever half-round the FSM is in.
module tea_decrypt_core
   import tea_pkg::*;
#(
   parameter int unsigned  ROUNDS = 32,
   parameter logic [31:0]  DELTA  = TEA_DELTA
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_v0,
   input  logic [31:0]   in_v1,
   input  logic [127:0]  in_key,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_v0,
   output logic [31:0]   out_v1,
   output logic          busy
);

   localparam logic [31:0] SUM_INIT = tea_sum_init(ROUNDS, DELTA);
   localparam logic [5:0]  RND_INIT = 6'(ROUNDS - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] v0_q, v0_d;
   logic [31:0] v1_q, v1_d;
   logic [31:0] sum_q, sum_d;
   logic [31:0] k0_q, k0_d;
   logic [31:0] k1_q, k1_d;
   logic [31:0] k2_q, k2_d;
   logic [31:0] k3_q, k3_d;
   logic [5:0]  rnd_q, rnd_d;
   logic [31:0] out_v0_q, out_v0_d;
   logic [31:0] out_v1_q, out_v1_d;

   logic [31:0] f_x;
   logic [31:0] f_ka;
   logic [31:0] f_kb;
   logic [31:0] f_val;

   // V1_STEP mixes v0 into v1 with (k2, k3); V0_STEP mixes the fresh v1 into v0 with (k0, k1).
   always_comb begin
      if (state_q == ST_V0_STEP) begin
         f_x  = v1_q;
         f_ka = k0_q;
         f_kb = k1_q;
      end else begin
         f_x  = v0_q;
         f_ka = k2_q;
         f_kb = k3_q;
      end
   end

   tea_f u_tea_f (
      .x  (f_x),
      .ka (f_ka),
      .kb (f_kb),
      .s  (sum_q),
      .f  (f_val)
   );

   always_comb begin
      state_d  = state_q;
      v0_d     = v0_q;
      v1_d     = v1_q;
      sum_d    = sum_q;
      k0_d     = k0_q;
      k1_d     = k1_q;
      k2_d     = k2_q;
      k3_d     = k3_q;
      rnd_d    = rnd_q;
      out_v0_d = out_v0_q;
      out_v1_d = out_v1_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               v0_d    = in_v0;
               v1_d    = in_v1;
               k0_d    = in_key[KEY_K0*32 +: 32];
               k1_d    = in_key[KEY_K1*32 +: 32];
               k2_d    = in_key[KEY_K2*32 +: 32];
               k3_d    = in_key[KEY_K3*32 +: 32];
               sum_d   = SUM_INIT;
               rnd_d   = RND_INIT;
               state_d = ST_V1_STEP;
            end
         end
         ST_V1_STEP: begin
            v1_d    = v1_q - f_val;
            state_d = ST_V0_STEP;
         end
         ST_V0_STEP: begin
            v0_d  = v0_q - f_val;
            sum_d = sum_q - DELTA;
            if (rnd_q == 6'd0) begin
               // Output registers only change here, so they hold across IDLE.
               out_v0_d = v0_d;
               out_v1_d = v1_q;
               state_d  = ST_DONE;
            end else begin
               rnd_d   = rnd_q - 6'd1;
               state_d = ST_V1_STEP;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         v0_q     <= '0;
         v1_q     <= '0;
         sum_q    <= '0;
         k0_q     <= '0;
         k1_q     <= '0;
         k2_q     <= '0;
         k3_q     <= '0;
         rnd_q    <= '0;
         out_v0_q <= '0;
         out_v1_q <= '0;
      end else begin
         state_q  <= state_d;
         v0_q     <= v0_d;
         v1_q     <= v1_d;
         sum_q    <= sum_d;
         k0_q     <= k0_d;
         k1_q     <= k1_d;
         k2_q     <= k2_d;
         k3_q     <= k3_d;
         rnd_q    <= rnd_d;
         out_v0_q <= out_v0_d;
         out_v1_q <= out_v1_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_V1_STEP) || (state_q == ST_V0_STEP);
   assign out_v0    = out_v0_q;
   assign out_v1    = out_v1_q;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Directed and round-trip bench for tea_decrypt_core, default build plus a ROUNDS=1 build.
module tb_tea_decrypt_core;

   localparam logic [31:0] DELTA = 32'h9E3779B9;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;

   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_v0 = '0;
   logic [31:0]  in_v1 = '0;
   logic [127:0] in_key = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_v0;
   logic [31:0]  out_v1;
   logic         busy;

   logic         r1_in_valid = 1'b0;
   logic         r1_in_ready;
   logic [31:0]  r1_in_v0 = '0;
   logic [31:0]  r1_in_v1 = '0;
   logic [127:0] r1_in_key = '0;
   logic         r1_out_valid;
   logic         r1_out_ready = 1'b0;
   logic [31:0]  r1_out_v0;
   logic [31:0]  r1_out_v1;
   logic         r1_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tea_decrypt_core dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_v0     (in_v0),
      .in_v1     (in_v1),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_v0    (out_v0),
      .out_v1    (out_v1),
      .busy      (busy)
   );

   tea_decrypt_core #(.ROUNDS(1)) dut_r1 (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (r1_in_valid),
      .in_ready  (r1_in_ready),
      .in_v0     (r1_in_v0),
      .in_v1     (r1_in_v1),
      .in_key    (r1_in_key),
      .out_valid (r1_out_valid),
      .out_ready (r1_out_ready),
      .out_v0    (r1_out_v0),
      .out_v1    (r1_out_v1),
      .busy      (r1_busy)
   );

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference TEA encryption; returns {v0, v1}.
   function automatic logic [63:0] tea_enc(input logic [31:0] p0, input logic [31:0] p1,
                                           input logic [127:0] key, input int rounds);
      logic [31:0] a, b, s, k0, k1, k2, k3;
      a = p0; b = p1; s = '0;
      k0 = key[31:0]; k1 = key[63:32]; k2 = key[95:64]; k3 = key[127:96];
      for (int i = 0; i < rounds; i++) begin
         s = s + DELTA;
         a = a + ((((b << 4) + k0) ^ (b + s)) ^ ((b >> 5) + k1));
         b = b + ((((a << 4) + k2) ^ (a + s)) ^ ((a >> 5) + k3));
      end
      return {a, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One block through the default DUT. Returns the result and cycles from accept to out_valid.
   task automatic do_block(input logic [31:0] v0, input logic [31:0] v1, input logic [127:0] key,
                           input bit scramble, input bit rand_ctl,
                           output logic [31:0] r0, output logic [31:0] r1, output int lat);
      int  guard;
      bit  hs;
      guard = 0;
      while (!in_ready && guard < 300) begin
         tick();
         guard++;
      end
      if (!in_ready) check32("in_ready_wait", 32'(in_ready), 32'd1);
      if (rand_ctl) begin
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
      end
      in_v0 = v0;
      in_v1 = v1;
      in_key = key;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (scramble) begin
         in_v0 = ~v0;
         in_v1 = v1 + 32'd1;
         in_key = ~key;
         in_valid = 1'b1;
      end
      lat = 0;
      while (!out_valid && lat < 300) begin
         if (rand_ctl) in_valid = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      if (!out_valid) check32("out_valid_wait", 32'(out_valid), 32'd1);
      r0 = out_v0;
      r1 = out_v1;
      hs = 1'b0;
      for (int i = 0; i < 8 && !hs; i++) begin
         out_ready = rand_ctl ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = out_ready;
         tick();
      end
      if (!hs) begin
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0]  r0, r1, p0, p1, hold0, hold1;
      logic [127:0] key;
      logic [63:0]  ct;
      int           lat, guard;

      // Reset values
      tick();
      tick();
      check32("rst_in_ready", 32'(in_ready), 32'd1);
      check32("rst_out_valid", 32'(out_valid), 32'd0);
      check32("rst_busy", 32'(busy), 32'd0);
      check32("rst_out_v0", out_v0, 32'd0);
      check32("rst_out_v1", out_v1, 32'd0);
      #2 resetn = 1'b1;
      tick();

      // Known answer: all-zero key and plaintext
      do_block(32'h41EA3A0A, 32'h94BAA940, 128'd0, 1'b0, 1'b0, r0, r1, lat);
      check32("kat_v0", r0, 32'h0);
      check32("kat_v1", r1, 32'h0);
      check32("kat_latency", 32'(lat), 32'd64);
      check32("kat_in_ready_after_hs", 32'(in_ready), 32'd1);
      check32("kat_out_valid_after_hs", 32'(out_valid), 32'd0);

      // Input change after accept, also leaves a nonzero result on the outputs
      key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      ct  = tea_enc(32'hDEADBEEF, 32'hCAFEF00D, key, 32);
      do_block(ct[63:32], ct[31:0], key, 1'b1, 1'b0, r0, r1, lat);
      check32("scramble_v0", r0, 32'hDEADBEEF);
      check32("scramble_v1", r1, 32'hCAFEF00D);
      check32("hold_idle_v0", out_v0, 32'hDEADBEEF);
      check32("hold_idle_v1", out_v1, 32'hCAFEF00D);

      // Backpressure in DONE
      key = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      ct  = tea_enc(32'h00000001, 32'h80000000, key, 32);
      in_v0 = ct[63:32];
      in_v1 = ct[31:0];
      in_key = key;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 300) begin
         tick();
         guard++;
      end
      check32("bp_reach_done", 32'(out_valid), 32'd1);
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'(i % 2);
         tick();
         check32("bp_out_valid", 32'(out_valid), 32'd1);
         check32("bp_in_ready", 32'(in_ready), 32'd0);
         check32("bp_v0", out_v0, 32'h00000001);
         check32("bp_v1", out_v1, 32'h80000000);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check32("bp_in_ready_after_hs", 32'(in_ready), 32'd1);

      // Reset during half-round 17
      key = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
      in_v0 = 32'h11111111;
      in_v1 = 32'h22222222;
      in_key = key;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check32("mid_busy_before_rst", 32'(busy), 32'd1);
      resetn = 1'b0;
      #1;
      check32("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check32("mid_rst_busy", 32'(busy), 32'd0);
      check32("mid_rst_out_v0", out_v0, 32'd0);
      check32("mid_rst_out_v1", out_v1, 32'd0);
      tick();
      #2 resetn = 1'b1;
      tick();
      do_block(32'h41EA3A0A, 32'h94BAA940, 128'd0, 1'b0, 1'b0, r0, r1, lat);
      check32("post_rst_kat_v0", r0, 32'h0);
      check32("post_rst_kat_v1", r1, 32'h0);

      // Random round trips with random handshake timing
      for (int n = 0; n < 200; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         p0  = $urandom;
         p1  = $urandom;
         ct  = tea_enc(p0, p1, key, 32);
         do_block(ct[63:32], ct[31:0], key, 1'b0, 1'b1, r0, r1, lat);
         check32("rt_v0", r0, p0);
         check32("rt_v1", r1, p1);
      end

      // ROUNDS=1 build
      key = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
      ct  = tea_enc(32'h13579BDF, 32'h2468ACE0, key, 1);
      r1_in_v0 = ct[63:32];
      r1_in_v1 = ct[31:0];
      r1_in_key = key;
      r1_in_valid = 1'b1;
      tick();
      r1_in_valid = 1'b0;
      check32("r1_sum_init", dut_r1.sum_q, DELTA);
      lat = 0;
      while (!r1_out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check32("r1_latency", 32'(lat), 32'd2);
      hold0 = r1_out_v0;
      hold1 = r1_out_v1;
      check32("r1_v0", hold0, 32'h13579BDF);
      check32("r1_v1", hold1, 32'h2468ACE0);
      r1_out_ready = 1'b1;
      tick();
      r1_out_ready = 1'b0;
      check32("r1_in_ready_after_hs", 32'(r1_in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
